mem_stream_writer: RTL and testbench

Drains a 64-bit word stream into SDRAM through an Avalon-MM write master, the write-side counterpart of the command reader. Producers (e.g. a readback/feedback engine) push words into an internal FIFO; the block writes them to consecutive 8-byte addresses starting at a fixed base, wrapping within a fixed-length region. A restart drains the in-flight write, clears the FIFO and rewinds the write pointer, so software can reuse the buffer.

---
 rtl/mem_stream_writer_pkg.sv | 17 +
 rtl/mem_stream_writer_fifo.sv | 62 ++++++
 rtl/mem_stream_writer.sv | 124 ++++++++++++
 tb/tb_mem_stream_writer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stream_writer_pkg.sv
// Shared types and widths for the SDRAM stream writer and its FIFO.
package mem_stream_writer_pkg;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 64;
    localparam logic [7:0] BURST_ONE = 8'h01;
    localparam logic [7:0] BYTE_ALL = 8'hFF;

    typedef enum logic [2:0] {
        INIT            = 3'd0,
        RESTART         = 3'd1,
        DRAIN           = 3'd2,
        CLEAR_FIFO_WAIT = 3'd3,
        COPY            = 3'd4
    } state_t;

endpackage

// File: rtl/mem_stream_writer_fifo.sv
// Show-ahead synchronous FIFO with a synchronous clear; pushes when full and
// pops when empty are ignored.
module mem_stream_writer_fifo
    import mem_stream_writer_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sclr,
    input  logic [DATA_W-1:0]     data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [DATA_W-1:0]     q,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   usedw
);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_write;
    logic                  do_read;

    assign empty    = (usedw == '0);
    assign do_write = wrreq && (usedw != (DEPTH_LOG2+1)'(DEPTH));
    assign do_read  = rdreq && !empty;
    assign q        = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_write && !sclr) begin
            mem[wr_ptr] <= data;
        end
    end

    // A clear wins over any push or pop in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
        end else if (sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, do_read})
                2'b10:   usedw <= usedw + 1'b1;
                2'b01:   usedw <= usedw - 1'b1;
                default: usedw <= usedw;
            endcase
        end
    end

endmodule

// File: rtl/mem_stream_writer.sv
// Drains a 64-bit word stream into a circular SDRAM region via an Avalon-MM
// write master; restart finishes the in-flight write, flushes and rewinds.
module mem_stream_writer
    import mem_stream_writer_pkg::*;
#(
    parameter int BASE_ADDRESS    = 0,
    parameter int LENGTH_WORDS    = 4096,
    parameter int FIFO_DEPTH      = 32,
    parameter int FIFO_DEPTH_LOG2 = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              restart,
    output logic              ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] write_address,
    output logic [7:0]        write_burstcount,
    output logic [7:0]        write_byteenable,
    output logic [DATA_W-1:0] write_writedata,
    output logic              write_write,
    input  logic              write_waitrequest,
    output logic              idle,
    output logic [ADDR_W-1:0] words_written
);

    localparam logic [ADDR_W-1:0] BASE_WORD = ADDR_W'(BASE_ADDRESS / 8);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(BASE_ADDRESS / 8 + LENGTH_WORDS - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] USEDW_LIMIT = (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH - 2);

    state_t                 state;
    logic [ADDR_W-1:0]      pc;
    logic                   fifo_sclr;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   stalled;
    logic [DATA_W-1:0]      fifo_q;
    logic [FIFO_DEPTH_LOG2:0] fifo_usedw;

    // Two entries of slack keep a word in flight from overflowing the FIFO.
    assign stalled          = write_write && write_waitrequest;
    assign in_ready         = (state == COPY) && !restart && (fifo_usedw < USEDW_LIMIT);
    assign ready            = (state == COPY) && !restart;
    assign idle             = (state == COPY) && fifo_empty && !write_write;
    assign fifo_push        = in_valid && in_ready;
    assign fifo_pop         = (state == COPY) && !restart && !stalled && !fifo_empty;
    assign write_burstcount = BURST_ONE;
    assign write_byteenable = BYTE_ALL;

    mem_stream_writer_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .sclr    (fifo_sclr),
        .data    (in_data),
        .wrreq   (fifo_push),
        .rdreq   (fifo_pop),
        .q       (fifo_q),
        .empty   (fifo_empty),
        .usedw   (fifo_usedw)
    );

    // A stalled write is never withdrawn, whatever the state; restart only
    // redirects the sequence once the bus lets go.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= INIT;
            pc              <= BASE_WORD;
            write_write     <= 1'b0;
            write_address   <= '0;
            write_writedata <= '0;
            words_written   <= '0;
            fifo_sclr       <= 1'b0;
        end else begin
            if (write_write && !write_waitrequest) begin
                words_written <= words_written + 1'b1;
            end
            if (!stalled) begin
                write_write <= 1'b0;
            end
            fifo_sclr <= 1'b0;

            case (state)
                INIT: begin
                    state <= INIT;
                end
                RESTART: begin
                    pc            <= BASE_WORD;
                    words_written <= '0;
                    state         <= DRAIN;
                end
                DRAIN: begin
                    if (!stalled) begin
                        fifo_sclr <= 1'b1;
                        state     <= CLEAR_FIFO_WAIT;
                    end
                end
                CLEAR_FIFO_WAIT: begin
                    state <= COPY;
                end
                COPY: begin
                    if (fifo_pop) begin
                        write_writedata <= fifo_q;
                        write_address   <= pc;
                        write_write     <= 1'b1;
                        pc              <= (pc == LAST_WORD) ? BASE_WORD : pc + 1'b1;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase

            if (restart) begin
                state <= RESTART;
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_writer.sv
// Bench for mem_stream_writer: two instances differing only in region length,
// checked every cycle against a queue-based transaction model.
module tb_mem_stream_writer;
    import mem_stream_writer_pkg::*;

    localparam int BASE_ADDRESS = 'h100;
    localparam int BASE_W       = 'h20;
    localparam int LEN_BIG      = 20;
    localparam int LEN_SMALL    = 4;
    localparam int DEPTH        = 8;
    localparam int DEPTH_LOG2   = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        restart = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        write_waitrequest = 1'b0;

    logic        b_ready, b_in_ready, b_write, b_idle;
    logic [28:0] b_address, b_count;
    logic [7:0]  b_burst, b_be;
    logic [63:0] b_data;
    logic        s_ready, s_in_ready, s_write, s_idle;
    logic [28:0] s_address, s_count;
    logic [7:0]  s_burst, s_be;
    logic [63:0] s_data;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_stream_writer #(
        .BASE_ADDRESS(BASE_ADDRESS), .LENGTH_WORDS(LEN_BIG),
        .FIFO_DEPTH(DEPTH), .FIFO_DEPTH_LOG2(DEPTH_LOG2)
    ) u_big (
        .clock(clock), .reset_n(reset_n), .restart(restart), .ready(b_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
        .write_address(b_address), .write_burstcount(b_burst),
        .write_byteenable(b_be), .write_writedata(b_data), .write_write(b_write),
        .write_waitrequest(write_waitrequest), .idle(b_idle), .words_written(b_count)
    );

    mem_stream_writer #(
        .BASE_ADDRESS(BASE_ADDRESS), .LENGTH_WORDS(LEN_SMALL),
        .FIFO_DEPTH(DEPTH), .FIFO_DEPTH_LOG2(DEPTH_LOG2)
    ) u_small (
        .clock(clock), .reset_n(reset_n), .restart(restart), .ready(s_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
        .write_address(s_address), .write_burstcount(s_burst),
        .write_byteenable(s_be), .write_writedata(s_data), .write_write(s_write),
        .write_waitrequest(write_waitrequest), .idle(s_idle), .words_written(s_count)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Transaction model: words waiting in the FIFO, the word on the bus, and
    // the edge bookkeeping that decides when a restart has finished flushing.
    logic [63:0] mq[$];
    bit          m_act, m_ww, m_pending;
    logic [63:0] m_data;
    logic [28:0] m_addr_b, m_addr_s, m_count;
    int          m_next_idx, r_edge, drain_edge, cyc;

    function automatic bit m_in_ready();
        return m_act && !restart && (mq.size() < DEPTH - 2);
    endfunction

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                m_act = 0; m_ww = 0; m_pending = 0;
                m_data = '0; m_addr_b = '0; m_addr_s = '0; m_count = '0;
                m_next_idx = 0; r_edge = 0; drain_edge = -1;
            end else begin
                bit          stalled;
                bit          push;
                logic [63:0] pushed;
                stalled = m_ww && write_waitrequest;
                push    = in_valid && m_in_ready();
                pushed  = in_data;
                if (m_ww && !write_waitrequest) m_count++;
                if (m_act && !restart && !stalled && mq.size() > 0) begin
                    m_data   = mq.pop_front();
                    m_addr_b = 29'(BASE_W + m_next_idx % LEN_BIG);
                    m_addr_s = 29'(BASE_W + m_next_idx % LEN_SMALL);
                    m_next_idx++;
                    m_ww = 1;
                end else if (!stalled) begin
                    m_ww = 0;
                end
                if (push) mq.push_back(pushed);
                if (restart) begin
                    m_act = 0; m_pending = 1; r_edge = cyc; drain_edge = -1;
                end else if (m_pending) begin
                    if (cyc == r_edge + 1) begin
                        m_next_idx = 0;
                        m_count    = '0;
                    end else if (drain_edge < 0) begin
                        if (cyc >= r_edge + 2 && !stalled) drain_edge = cyc;
                    end else begin
                        mq.delete();
                        m_act = 1;
                        m_pending = 0;
                    end
                end
                cyc++;
            end
        end
    end

    logic [28:0] log_b_addr[$];
    logic [63:0] log_b_data[$];
    logic [28:0] log_s_addr[$];
    time         log_time[$];

    initial begin
        forever begin
            @(negedge clock);
            checkOutput("write_write_big", b_write, m_ww);
            checkOutput("write_write_small", s_write, m_ww);
            checkOutput("writedata_big", b_data, m_data);
            checkOutput("writedata_small", s_data, m_data);
            checkOutput("address_big", b_address, m_addr_b);
            checkOutput("address_small", s_address, m_addr_s);
            checkOutput("in_ready_big", b_in_ready, m_in_ready());
            checkOutput("in_ready_small", s_in_ready, m_in_ready());
            checkOutput("ready", b_ready, m_act && !restart);
            checkOutput("idle", b_idle, m_act && mq.size() == 0 && !m_ww);
            checkOutput("words_written_big", b_count, m_count);
            checkOutput("words_written_small", s_count, m_count);
            checkOutput("burstcount", b_burst, 8'h01);
            checkOutput("byteenable", b_be, 8'hFF);
            if (b_write && !write_waitrequest) begin
                log_b_addr.push_back(b_address);
                log_b_data.push_back(b_data);
                log_s_addr.push_back(s_address);
                log_time.push_back($time);
            end
        end
    end

    task automatic applyStimulus(input bit valid, input logic [63:0] data, output bit accepted);
        in_valid = valid;
        in_data  = valid ? data : 64'h0;
        #2;
        accepted = valid && b_in_ready;
        @(posedge clock);
        #2;
    endtask

    task automatic stepIdle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 64'h0, acc);
    endtask

    task automatic pushWord(input logic [63:0] data);
        bit acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) applyStimulus(1'b1, data, acc);
        checkOutput("push_accepted", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic waitReady();
        for (int t = 0; t < 20 && !b_ready; t++) stepIdle(1);
        checkOutput("ready_reached", b_ready, 1);
    endtask

    task automatic clearLogs();
        log_b_addr.delete();
        log_b_data.delete();
        log_s_addr.delete();
        log_time.delete();
    endtask

    logic [28:0] wrap_exp [6] = '{29'h20, 29'h21, 29'h22, 29'h23, 29'h20, 29'h21};

    initial begin
        bit acc;
        bit saw_low;

        // Reset, then INIT ignores input until the first restart.
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        checkOutput("reset_write", b_write, 0);
        checkOutput("reset_in_ready", b_in_ready, 0);
        checkOutput("reset_count", b_count, 0);
        reset_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'hDEAD;
        repeat (100) begin
            @(posedge clock);
            #2;
        end
        checkOutput("init_in_ready", b_in_ready, 0);
        checkOutput("init_write", b_write, 0);
        in_valid = 1'b0;

        // Restart with nothing pending reaches COPY three edges later.
        restart = 1'b1;
        applyStimulus(1'b0, 64'h0, acc);
        restart = 1'b0;
        checkOutput("ready_r0", b_ready, 0);
        stepIdle(1);
        checkOutput("ready_r1", b_ready, 0);
        stepIdle(1);
        checkOutput("ready_r2", b_ready, 0);
        stepIdle(1);
        checkOutput("ready_r3", b_ready, 1);

        // Streaming 1..16 with no backpressure.
        clearLogs();
        applyStimulus(1'b1, 64'h1, acc);
        checkOutput("first_accept", acc, 1);
        checkOutput("latency_e0_write", b_write, 0);
        applyStimulus(1'b1, 64'h2, acc);
        checkOutput("latency_e1_write", b_write, 1);
        checkOutput("latency_e1_data", b_data, 64'h1);
        checkOutput("latency_e1_addr", b_address, 29'h20);
        for (int i = 3; i <= 16; i++) pushWord(64'(i));
        stepIdle(4);
        checkOutput("stream_count", log_b_addr.size(), 16);
        for (int i = 0; i < 16; i++) begin
            checkOutput("stream_addr", log_b_addr[i], 64'(29'h20 + i));
            checkOutput("stream_data", log_b_data[i], 64'(i + 1));
        end
        checkOutput("stream_span", log_time[15] - log_time[0], 150);
        checkOutput("stream_words_written", b_count, 16);
        for (int i = 0; i < 6; i++) checkOutput("wrap_addr", log_s_addr[i], wrap_exp[i]);

        // Backpressure: five stalled cycles while the FIFO fills to its limit.
        clearLogs();
        saw_low = 1'b0;
        applyStimulus(1'b1, 64'h101, acc);
        applyStimulus(1'b1, 64'h102, acc);
        write_waitrequest = 1'b1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 64'h103 + 64'(k), acc);
            checkOutput("stall_write", b_write, 1);
            checkOutput("stall_addr", b_address, 29'h30);
            checkOutput("stall_data", b_data, 64'h101);
            if (!b_in_ready) saw_low = 1'b1;
        end
        checkOutput("stall_in_ready_low", b_in_ready, 0);
        checkOutput("stall_saw_low", saw_low, 1);
        write_waitrequest = 1'b0;
        pushWord(64'h108);
        stepIdle(10);
        checkOutput("bp_count", log_b_data.size(), 8);
        for (int i = 0; i < 8; i++) checkOutput("bp_data", log_b_data[i], 64'h101 + 64'(i));
        checkOutput("bp_words_written", b_count, 24);

        // Restart while a write is stalled on the bus.
        write_waitrequest = 1'b1;
        pushWord(64'hAAA);
        pushWord(64'hB1);
        pushWord(64'hB2);
        restart = 1'b1;
        applyStimulus(1'b1, 64'hCC, acc);
        restart = 1'b0;
        in_valid = 1'b0;
        checkOutput("rs_accept_cc", acc, 0);
        checkOutput("rs_hold_r0", b_write, 1);
        checkOutput("rs_hold_data", b_data, 64'hAAA);
        stepIdle(1);
        checkOutput("rs_hold_r1", b_write, 1);
        checkOutput("rs_count_zero", b_count, 0);
        stepIdle(1);
        checkOutput("rs_hold_r2", b_write, 1);
        checkOutput("rs_not_ready", b_ready, 0);
        write_waitrequest = 1'b0;
        waitReady();
        clearLogs();
        pushWord(64'hD1);
        pushWord(64'hD2);
        stepIdle(4);
        checkOutput("rs_log_size", log_b_addr.size(), 2);
        checkOutput("rs_addr0", log_b_addr[0], 29'h20);
        checkOutput("rs_data0", log_b_data[0], 64'hD1);
        checkOutput("rs_addr1", log_b_addr[1], 29'h21);
        checkOutput("rs_data1", log_b_data[1], 64'hD2);
        checkOutput("rs_small_addr0", log_s_addr[0], 29'h20);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 6; i++) pushWord(64'hE0 + 64'(i));
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("areset_write", b_write, 0);
        checkOutput("areset_write_small", s_write, 0);
        checkOutput("areset_addr", b_address, 0);
        checkOutput("areset_data", b_data, 0);
        checkOutput("areset_count", b_count, 0);
        checkOutput("areset_in_ready", b_in_ready, 0);
        checkOutput("areset_ready", b_ready, 0);
        checkOutput("areset_idle", b_idle, 0);
        in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        stepIdle(5);
        checkOutput("post_reset_in_ready", b_in_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
